// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction-fetch stage: PC owner, single-outstanding cache request, decode slot
module if_fetch_unit #(
   parameter int                 WIDTH    = 32,
   parameter logic [WIDTH-1:0]   RESET_PC = 32'hBFC0_0000
) (
   input  logic             clk,
   input  logic             rst,
   output logic [WIDTH-1:0] pc,
   input  logic [WIDTH-1:0] pc_plus4,
   input  logic             redirect,
   input  logic [WIDTH-1:0] redirect_pc,
   output logic             inst_req,
   output logic [WIDTH-1:0] inst_addr,
   input  logic             inst_valid,
   input  logic [WIDTH-1:0] inst_rdata,
   output logic             if_valid,
   output logic [WIDTH-1:0] if_pc,
   output logic [WIDTH-1:0] if_inst,
   input  logic             id_ready
);

   localparam logic [WIDTH-1:0] ALIGN_MASK = {{(WIDTH-2){1'b1}}, 2'b00};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] pc_n, tgt, tgt_n, if_pc_n, if_inst_n;
   logic             pend, pend_n, if_valid_n;
   logic [WIDTH-1:0] redirect_aligned;

   assign redirect_aligned = redirect_pc & ALIGN_MASK;
   assign inst_addr        = pc;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         pc       <= RESET_PC;
         pend     <= 1'b0;
         tgt      <= '0;
         if_valid <= 1'b0;
         if_pc    <= '0;
         if_inst  <= '0;
      end else begin
         state    <= state_n;
         pc       <= pc_n;
         pend     <= pend_n;
         tgt      <= tgt_n;
         if_valid <= if_valid_n;
         if_pc    <= if_pc_n;
         if_inst  <= if_inst_n;
      end
   end

   always_comb begin
      state_n    = state;
      pc_n       = pc;
      pend_n     = pend;
      tgt_n      = tgt;
      if_valid_n = if_valid;
      if_pc_n    = if_pc;
      if_inst_n  = if_inst;
      inst_req   = 1'b0;

      case (state)
         IDLE: begin
            state_n = FETCH;
            if (redirect) pc_n = redirect_aligned;
         end

         FETCH: begin
            inst_req = 1'b1;
            if (redirect) begin
               // An in-flight access cannot be cancelled; park the target until it returns.
               if (inst_valid) begin
                  pc_n   = redirect_aligned;
                  pend_n = 1'b0;
               end else begin
                  pend_n = 1'b1;
                  tgt_n  = redirect_aligned;
               end
            end else if (inst_valid) begin
               if (pend) begin
                  pc_n   = tgt;
                  pend_n = 1'b0;
               end else begin
                  if_inst_n  = inst_rdata;
                  if_pc_n    = pc;
                  if_valid_n = 1'b1;
                  pc_n       = pc_plus4 & ALIGN_MASK;
                  state_n    = FULL;
               end
            end
         end

         FULL: begin
            if (redirect) begin
               if_valid_n = 1'b0;
               pc_n       = redirect_aligned;
               state_n    = FETCH;
            end else if (id_ready) begin
               if_valid_n = 1'b0;
               state_n    = FETCH;
            end
         end

         default: state_n = IDLE;
      endcase
   end

endmodule
